// File: rtl/ocm_stream_writer_if.sv
`default_nettype none
// ============================================================================
// Module : ocm_stream_writer_if
// Brief  : Stream sink, OCM Avalon master and CSR slave bundle for the writer.
// Rev    : 1.0
// ============================================================================
interface ocm_stream_writer_if #(
  parameter int ADDR_W = 11
);
  logic [31:0]       snk_data;
  logic              snk_valid;
  logic              snk_ready;
  logic [ADDR_W-1:0] m_address;
  logic              m_chipselect;
  logic              m_write;
  logic [3:0]        m_byteenable;
  logic [31:0]       m_writedata;
  logic              m_clken;
  logic [1:0]        csr_address;
  logic              csr_read;
  logic              csr_write;
  logic [31:0]       csr_writedata;
  logic [31:0]       csr_readdata;
  logic              irq;

  // The writer itself: stream sink, OCM master, CSR slave.
  modport master (
    input  snk_data, snk_valid,
    output snk_ready,
    output m_address, m_chipselect, m_write, m_byteenable, m_writedata, m_clken,
    input  csr_address, csr_read, csr_write, csr_writedata,
    output csr_readdata, irq
  );

  // The surroundings: stream source, OCM, CPU.
  modport slave (
    output snk_data, snk_valid,
    input  snk_ready,
    input  m_address, m_chipselect, m_write, m_byteenable, m_writedata, m_clken,
    output csr_address, csr_read, csr_write, csr_writedata,
    input  csr_readdata, irq
  );
endinterface
`default_nettype wire

// File: rtl/ocm_stream_writer.sv
`default_nettype none
// ============================================================================
// Module : ocm_stream_writer
// Brief  : Writes a 32-bit valid/ready stream into OCM as a circular buffer,
//          with a 4-word CSR block for pointers, status and interrupt.
// Rev    : 1.0
// ============================================================================
module ocm_stream_writer #(
  parameter int ADDR_W         = 11,
  parameter bit DROP_WHEN_FULL = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  ocm_stream_writer_if.master  bus
);
  localparam int              PW        = ADDR_W + 1;
  localparam logic [PW-1:0]   DEPTH     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [1:0]      REG_CTRL  = 2'd0;
  localparam logic [1:0]      REG_WRPTR = 2'd1;
  localparam logic [1:0]      REG_RDPTR = 2'd2;
  localparam logic [1:0]      REG_STAT  = 2'd3;

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     thresh_q, thresh_d;
  logic              en_q, en_d, irq_en_q, irq_en_d;
  logic              ovf_q, ovf_d, err_q, err_d;
  logic              wr_vld_q, wr_vld_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              irq_q, irq_d;

  logic [PW-1:0]     count, count_d, new_rd, rd_gap;
  logic              full, empty, ready, accept, drop;
  logic [31:0]       rd_word;
  logic              unused_wdata;

  assign count  = wr_ptr_q - rd_ptr_q;
  assign full   = (count == DEPTH);
  assign empty  = (count == '0);
  assign accept = bus.snk_valid & ready & ~full;
  assign unused_wdata = ^bus.csr_writedata;

  generate
    if (DROP_WHEN_FULL) begin : g_drop
      assign ready = en_q;
      assign drop  = bus.snk_valid & en_q & full;
    end else begin : g_backpressure
      assign ready = en_q & ~full;
      assign drop  = 1'b0;
    end
  endgenerate

  always_comb begin
    rd_word = '0;
    case (bus.csr_address)
      REG_CTRL: begin
        rd_word[0]             = en_q;
        rd_word[2]             = irq_en_q;
        rd_word[ADDR_W+16:16]  = thresh_q;
      end
      REG_WRPTR: rd_word[ADDR_W:0] = wr_ptr_q;
      REG_RDPTR: rd_word[ADDR_W:0] = rd_ptr_q;
      default: begin
        rd_word[ADDR_W:0] = count;
        rd_word[16]       = empty;
        rd_word[17]       = full;
        rd_word[18]       = ovf_q;
        rd_word[19]       = err_q;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q + PW'(accept);
    rd_ptr_d  = rd_ptr_q;
    thresh_d  = thresh_q;
    en_d      = en_q;
    irq_en_d  = irq_en_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    new_rd    = bus.csr_writedata[ADDR_W:0];
    rd_gap    = wr_ptr_d - new_rd;
    wr_vld_d  = accept;
    wr_addr_d = accept ? wr_ptr_q[ADDR_W-1:0] : wr_addr_q;
    wr_data_d = accept ? bus.snk_data : wr_data_q;
    rdata_d   = bus.csr_read ? rd_word : 32'd0;

    // Legality is judged against the write pointer including this cycle's beat.
    if (bus.csr_write && bus.csr_address == REG_RDPTR) begin
      if (rd_gap <= DEPTH) rd_ptr_d = new_rd;
      else                 err_d    = 1'b1;
    end
    if (bus.csr_write && bus.csr_address == REG_STAT) begin
      if (bus.csr_writedata[18]) ovf_d = 1'b0;
      if (bus.csr_writedata[19]) err_d = 1'b0;
    end
    if (drop) ovf_d = 1'b1;

    if (bus.csr_write && bus.csr_address == REG_CTRL) begin
      en_d     = bus.csr_writedata[0];
      irq_en_d = bus.csr_writedata[2];
      thresh_d = bus.csr_writedata[ADDR_W+16:16];
      // The OCM write of a colliding beat still goes out; only its pointer
      // advance is lost.
      if (bus.csr_writedata[1]) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        ovf_d    = 1'b0;
        err_d    = 1'b0;
      end
    end

    count_d = wr_ptr_d - rd_ptr_d;
    irq_d   = irq_en_d & (thresh_d != '0) & (count_d >= thresh_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      thresh_q  <= '0;
      en_q      <= 1'b0;
      irq_en_q  <= 1'b0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      wr_vld_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      thresh_q  <= thresh_d;
      en_q      <= en_d;
      irq_en_q  <= irq_en_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
      wr_vld_q  <= wr_vld_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
    end
  end

  assign bus.snk_ready    = ready;
  assign bus.m_chipselect = wr_vld_q;
  assign bus.m_write      = wr_vld_q;
  assign bus.m_address    = wr_addr_q;
  assign bus.m_writedata  = wr_data_q;
  assign bus.m_byteenable = 4'hF;
  assign bus.m_clken      = 1'b1;
  assign bus.csr_readdata = rdata_q;
  assign bus.irq          = irq_q;
endmodule
`default_nettype wire

// File: tb/tb_ocm_stream_writer.sv
`default_nettype none
// ============================================================================
// Module : tb_ocm_stream_writer
// Brief  : Drives a backpressure and a drop-mode writer with identical stimulus
//          and compares each against an integer buffer model.
// Rev    : 1.0
// ============================================================================
module tb_ocm_stream_writer;
  localparam int AW    = 11;
  localparam int DEPTH = 2048;
  localparam int PMOD  = 4096;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [31:0] s_data;
  logic        s_valid;
  logic [1:0]  c_addr;
  logic        c_rd, c_wr;
  logic [31:0] c_wdata;

  ocm_stream_writer_if #(.ADDR_W(AW)) bus0 ();
  ocm_stream_writer_if #(.ADDR_W(AW)) bus1 ();

  assign bus0.snk_data = s_data;  assign bus1.snk_data = s_data;
  assign bus0.snk_valid = s_valid; assign bus1.snk_valid = s_valid;
  assign bus0.csr_address = c_addr; assign bus1.csr_address = c_addr;
  assign bus0.csr_read = c_rd;     assign bus1.csr_read = c_rd;
  assign bus0.csr_write = c_wr;    assign bus1.csr_write = c_wr;
  assign bus0.csr_writedata = c_wdata; assign bus1.csr_writedata = c_wdata;

  ocm_stream_writer #(.ADDR_W(AW), .DROP_WHEN_FULL(1'b0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0.master));
  ocm_stream_writer #(.ADDR_W(AW), .DROP_WHEN_FULL(1'b1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1.master));

  logic        o_ready[2], o_write[2], o_cs[2], o_irq[2], o_clken[2];
  logic [10:0] o_addr[2];
  logic [31:0] o_wdata[2], o_rdata[2];
  logic [3:0]  o_be[2];
  assign o_ready[0] = bus0.snk_ready;    assign o_ready[1] = bus1.snk_ready;
  assign o_write[0] = bus0.m_write;      assign o_write[1] = bus1.m_write;
  assign o_cs[0]    = bus0.m_chipselect; assign o_cs[1]    = bus1.m_chipselect;
  assign o_irq[0]   = bus0.irq;          assign o_irq[1]   = bus1.irq;
  assign o_clken[0] = bus0.m_clken;      assign o_clken[1] = bus1.m_clken;
  assign o_addr[0]  = bus0.m_address;    assign o_addr[1]  = bus1.m_address;
  assign o_wdata[0] = bus0.m_writedata;  assign o_wdata[1] = bus1.m_writedata;
  assign o_rdata[0] = bus0.csr_readdata; assign o_rdata[1] = bus1.csr_readdata;
  assign o_be[0]    = bus0.m_byteenable; assign o_be[1]    = bus1.m_byteenable;

  // Reference model: index 0 = backpressure unit, index 1 = drop unit.
  int          m_wr[2], m_rd[2], m_thr[2];
  bit          m_en[2], m_irqen[2], m_ovf[2], m_err[2];
  bit          e_write[2], e_irq[2];
  logic [10:0] e_addr[2];
  logic [31:0] e_wdata[2], e_rdata[2];
  int          checks = 0;
  int          errors = 0;

  function automatic int cnt(int d);
    return (m_wr[d] - m_rd[d] + PMOD) % PMOD;
  endfunction

  function automatic bit exp_ready(int d);
    if (d == 1) return m_en[d];
    return m_en[d] && (cnt(d) != DEPTH);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_wr[d] = 0; m_rd[d] = 0; m_thr[d] = 0;
      m_en[d] = 0; m_irqen[d] = 0; m_ovf[d] = 0; m_err[d] = 0;
      e_write[d] = 0; e_irq[d] = 0; e_addr[d] = '0; e_wdata[d] = '0; e_rdata[d] = '0;
    end
  endtask

  // Advances the model by one clock using the inputs presented right now.
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int c, nwr, nr;
      bit full, acc, drp;
      c    = cnt(d);
      full = (c == DEPTH);
      acc  = s_valid && exp_ready(d) && !full;
      drp  = (d == 1) && s_valid && m_en[d] && full;
      e_rdata[d] = 32'd0;
      if (c_rd) begin
        case (c_addr)
          2'd0: e_rdata[d] = 32'(m_en[d]) | (32'(m_irqen[d]) << 2) | (32'(m_thr[d]) << 16);
          2'd1: e_rdata[d] = 32'(m_wr[d]);
          2'd2: e_rdata[d] = 32'(m_rd[d]);
          default: e_rdata[d] = 32'(c) | (32'(c == 0) << 16) | (32'(full) << 17)
                                | (32'(m_ovf[d]) << 18) | (32'(m_err[d]) << 19);
        endcase
      end
      e_write[d] = acc;
      if (acc) begin
        e_addr[d]  = 11'(m_wr[d] % DEPTH);
        e_wdata[d] = s_data;
      end
      nwr = (m_wr[d] + int'(acc)) % PMOD;
      if (c_wr && c_addr == 2'd2) begin
        nr = int'(c_wdata & 32'hFFF);
        if ((nwr - nr + PMOD) % PMOD <= DEPTH) m_rd[d] = nr;
        else m_err[d] = 1;
      end
      if (c_wr && c_addr == 2'd3) begin
        if (c_wdata[18]) m_ovf[d] = 0;
        if (c_wdata[19]) m_err[d] = 0;
      end
      if (drp) m_ovf[d] = 1;
      m_wr[d] = nwr;
      if (c_wr && c_addr == 2'd0) begin
        m_en[d]    = c_wdata[0];
        m_irqen[d] = c_wdata[2];
        m_thr[d]   = int'((c_wdata >> 16) & 32'hFFF);
        if (c_wdata[1]) begin
          m_wr[d] = 0; m_rd[d] = 0; m_ovf[d] = 0; m_err[d] = 0;
        end
      end
      e_irq[d] = m_irqen[d] && (m_thr[d] != 0) && (cnt(d) >= m_thr[d]);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr_op(input logic [1:0] a, input logic [31:0] v);
    c_wr = 1'b1; c_addr = a; c_wdata = v;
    step();
    c_wr = 1'b0;
  endtask

  task automatic csr_rd_op(input logic [1:0] a);
    c_rd = 1'b1; c_addr = a;
    step();
    c_rd = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; s_valid = 0; s_data = '0; c_rd = 0; c_wr = 0; c_addr = '0; c_wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_ready[d] !== 1'b0 || o_write[d] !== 1'b0 || o_cs[d] !== 1'b0 || o_addr[d] !== '0
          || o_wdata[d] !== '0 || o_rdata[d] !== '0 || o_irq[d] !== 1'b0
          || o_be[d] !== 4'hF || o_clken[d] !== 1'b1) begin
        errors++;
        $display("FAIL reset dut%0d: rdy=%b we=%b cs=%b addr=%h wd=%h rd=%h irq=%b be=%h clken=%b, want all 0 with be=f clken=1",
                 d, o_ready[d], o_write[d], o_cs[d], o_addr[d], o_wdata[d], o_rdata[d], o_irq[d], o_be[d], o_clken[d]);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_basic_burst();
    csr_wr_op(2'd0, 32'h1);
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = 32'hA0 + 32'(i);
      step();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (o_write[d] !== 1'b1 || o_cs[d] !== 1'b1 || o_addr[d] !== 11'(i) || o_wdata[d] !== 32'hA0 + 32'(i)) begin
          errors++;
          $display("FAIL burst_write dut%0d beat%0d: got we=%b cs=%b addr=%0d data=%h, want we=1 cs=1 addr=%0d data=%h",
                   d, i, o_write[d], o_cs[d], o_addr[d], o_wdata[d], i, 32'hA0 + 32'(i));
        end
      end
    end
    s_valid = 1'b0;
    step();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_write[d] !== 1'b0) begin
        errors++; $display("FAIL burst_idle dut%0d: got we=%b, want 0", d, o_write[d]);
      end
    end
    for (int r = 1; r <= 3; r += 2) begin
      csr_rd_op(2'(r));
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (o_rdata[d] !== e_rdata[d]) begin
          errors++; $display("FAIL burst_csr%0d dut%0d: got %h, want %h", r, d, o_rdata[d], e_rdata[d]);
        end
      end
    end
  endtask

  task automatic test_fill();
    int guard;
    csr_wr_op(2'd0, 32'h3);
    guard = 0;
    while (m_wr[0] != DEPTH && guard < 6000) begin
      s_valid = ($urandom_range(0, 3) != 0); s_data = $urandom;
      step();
      guard++;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (o_write[d] !== e_write[d] || o_ready[d] !== exp_ready(d)
            || (e_write[d] && (o_addr[d] !== e_addr[d] || o_wdata[d] !== e_wdata[d]))) begin
          errors++;
          $display("FAIL fill dut%0d: got we=%b rdy=%b addr=%0d data=%h, want we=%b rdy=%b addr=%0d data=%h",
                   d, o_write[d], o_ready[d], o_addr[d], o_wdata[d], e_write[d], exp_ready(d), e_addr[d], e_wdata[d]);
        end
      end
    end
    checks++;
    if (guard >= 6000) begin
      errors++; $display("FAIL fill_timeout: got wr=%0d, want %0d", m_wr[0], DEPTH);
    end
    s_valid = 1'b0;
    checks++;
    if (o_ready[0] !== 1'b0 || o_ready[1] !== 1'b1) begin
      errors++; $display("FAIL full_ready: got bp=%b drop=%b, want bp=0 drop=1", o_ready[0], o_ready[1]);
    end
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = $urandom;
      step();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (o_write[d] !== 1'b0) begin
          errors++; $display("FAIL full_nowrite dut%0d: got we=%b, want 0", d, o_write[d]);
        end
      end
    end
    s_valid = 1'b0;
    csr_rd_op(2'd3);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_rdata[d] !== e_rdata[d] || o_rdata[d][18] !== 1'(d)) begin
        errors++; $display("FAIL full_status dut%0d: got %h, want %h", d, o_rdata[d], e_rdata[d]);
      end
    end
    csr_wr_op(2'd3, 32'h1 << 18);
    csr_rd_op(2'd3);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_rdata[d] !== e_rdata[d] || o_rdata[d][18] !== 1'b0) begin
        errors++; $display("FAIL ovf_w1c dut%0d: got %h, want %h", d, o_rdata[d], e_rdata[d]);
      end
    end
    csr_wr_op(2'd2, 32'd1);
    checks++;
    if (o_ready[0] !== 1'b1 || o_ready[1] !== 1'b1) begin
      errors++; $display("FAIL ready_return: got bp=%b drop=%b, want 1 1", o_ready[0], o_ready[1]);
    end
    s_valid = 1'b1; s_data = $urandom;
    step();
    s_valid = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_write[d] !== 1'b1 || o_addr[d] !== 11'd0 || o_wdata[d] !== e_wdata[d]) begin
        errors++; $display("FAIL wrap_write dut%0d: got we=%b addr=%0d data=%h, want we=1 addr=0 data=%h",
                           d, o_write[d], o_addr[d], o_wdata[d], e_wdata[d]);
      end
    end
    csr_rd_op(2'd1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_rdata[d] !== 32'd2049) begin
        errors++; $display("FAIL wrap_wrptr dut%0d: got %0d, want 2049", d, o_rdata[d]);
      end
    end
  endtask

  task automatic test_rdptr_err();
    csr_wr_op(2'd0, 32'h3);
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin s_data = $urandom; step(); end
    s_valid = 1'b0;
    csr_wr_op(2'd2, 32'd10);
    for (int r = 2; r <= 3; r++) begin
      csr_rd_op(2'(r));
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (o_rdata[d] !== e_rdata[d]) begin
          errors++; $display("FAIL rdptr_err_csr%0d dut%0d: got %h, want %h", r, d, o_rdata[d], e_rdata[d]);
        end
      end
    end
    checks++;
    if (o_rdata[0][19] !== 1'b1) begin
      errors++; $display("FAIL err_flag: got %b, want 1", o_rdata[0][19]);
    end
    csr_wr_op(2'd3, 32'h1 << 19);
    csr_rd_op(2'd3);
    checks++;
    if (o_rdata[0] !== e_rdata[0] || o_rdata[0][19] !== 1'b0) begin
      errors++; $display("FAIL err_w1c: got %h, want %h", o_rdata[0], e_rdata[0]);
    end
  endtask

  task automatic test_irq();
    csr_wr_op(2'd0, (32'd4 << 16) | 32'h7);
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data = $urandom;
      step();
      checks++;
      if (o_irq[0] !== e_irq[0] || o_irq[1] !== e_irq[1] || o_irq[0] !== (i == 3)) begin
        errors++; $display("FAIL irq_rise beat%0d: got %b/%b, want %b", i, o_irq[0], o_irq[1], e_irq[0]);
      end
    end
    s_valid = 1'b0;
    csr_wr_op(2'd2, 32'd1);
    checks++;
    if (o_irq[0] !== 1'b0 || o_irq[1] !== 1'b0 || e_irq[0]) begin
      errors++; $display("FAIL irq_fall: got %b/%b, want 0", o_irq[0], o_irq[1]);
    end
  endtask

  task automatic test_clear_collision();
    csr_wr_op(2'd0, 32'h3);
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin s_data = $urandom; step(); end
    s_data = 32'hC0FFEE00;
    c_wr = 1'b1; c_addr = 2'd0; c_wdata = 32'h3;
    step();
    c_wr = 1'b0; s_valid = 1'b0;
    checks++;
    if (o_write[0] !== 1'b1 || o_addr[0] !== 11'd3 || o_wdata[0] !== 32'hC0FFEE00) begin
      errors++; $display("FAIL clear_collide_write: got we=%b addr=%0d data=%h, want we=1 addr=3 data=c0ffee00",
                         o_write[0], o_addr[0], o_wdata[0]);
    end
    for (int r = 1; r <= 3; r++) begin
      csr_rd_op(2'(r));
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (o_rdata[d] !== e_rdata[d]) begin
          errors++; $display("FAIL clear_collide_csr%0d dut%0d: got %h, want %h", r, d, o_rdata[d], e_rdata[d]);
        end
      end
    end
  endtask

  task automatic test_random();
    csr_wr_op(2'd0, 32'h3);
    for (int n = 0; n < 2500; n++) begin
      int op, c;
      s_valid = ($urandom_range(0, 3) != 0); s_data = $urandom;
      op = int'($urandom_range(0, 19));
      if (op <= 3) begin
        c_rd = 1'b1; c_addr = 2'($urandom_range(0, 3));
      end else if (op == 4) begin
        c = cnt(0);
        c_wr = 1'b1; c_addr = 2'd2;
        c_wdata = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, PMOD - 1))
                                              : 32'((m_rd[0] + int'($urandom_range(0, c))) % PMOD);
      end else if (op == 5) begin
        c_wr = 1'b1; c_addr = 2'd0;
        c_wdata = (32'($urandom_range(0, 40)) << 16) | 32'($urandom_range(0, 1) << 2)
                  | 32'($urandom_range(0, 7) != 0) | 32'(($urandom_range(0, 7) == 0) << 1);
      end else if (op == 6) begin
        c_wr = 1'b1; c_addr = 2'd3; c_wdata = $urandom;
      end
      step();
      c_rd = 1'b0; c_wr = 1'b0;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (o_write[d] !== e_write[d] || o_ready[d] !== exp_ready(d) || o_irq[d] !== e_irq[d]
            || o_rdata[d] !== e_rdata[d]
            || (e_write[d] && (o_addr[d] !== e_addr[d] || o_wdata[d] !== e_wdata[d]))) begin
          errors++;
          $display("FAIL random cyc%0d dut%0d: got we=%b rdy=%b irq=%b rd=%h addr=%0d data=%h, want we=%b rdy=%b irq=%b rd=%h addr=%0d data=%h",
                   n, d, o_write[d], o_ready[d], o_irq[d], o_rdata[d], o_addr[d], o_wdata[d],
                   e_write[d], exp_ready(d), e_irq[d], e_rdata[d], e_addr[d], e_wdata[d]);
        end
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    csr_wr_op(2'd0, (32'd1 << 16) | 32'h7);
    s_valid = 1'b1; s_data = 32'h5555AAAA;
    step();
    c_rd = 1'b1; c_addr = 2'd1;
    step();
    c_rd = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_ready[d] !== 1'b0 || o_write[d] !== 1'b0 || o_cs[d] !== 1'b0 || o_addr[d] !== '0
          || o_wdata[d] !== '0 || o_rdata[d] !== '0 || o_irq[d] !== 1'b0) begin
        errors++;
        $display("FAIL async_reset dut%0d: rdy=%b we=%b cs=%b addr=%h wd=%h rd=%h irq=%b, want all 0",
                 d, o_ready[d], o_write[d], o_cs[d], o_addr[d], o_wdata[d], o_rdata[d], o_irq[d]);
      end
    end
    s_valid = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step();
    checks++;
    if (o_ready[0] !== 1'b0 || o_ready[1] !== 1'b0) begin
      errors++; $display("FAIL post_reset_ready: got %b/%b, want 0", o_ready[0], o_ready[1]);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_burst();
    test_fill();
    test_rdptr_err();
    test_irq();
    test_clear_collision();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ocm_stream_writer.md
Name: ocm_stream_writer

Overview:
- Upstream feeder for a CPU on-chip memory: 2048x32 single-port RAM, Avalon slave, byte enables, no waitrequest, 1-cycle write.
- Accepts a 32-bit valid/ready stream and writes beats into the OCM as a circular buffer.
- Exposes a 4-register Avalon CSR so the CPU can read the write pointer, advance the read pointer and take an interrupt.
- Forms the producer half of one FIFO channel in the dual-FIFO system.

Parameters:
- ADDR_W, 11, OCM word-address width; buffer depth is 2**ADDR_W words.
- DROP_WHEN_FULL, 0, 0 = backpressure the source when full; 1 = keep ready high while enabled and drop beats when full.

Ports:
- clk  in  1  system clock; all logic is synchronous to its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- snk_data  in  32  stream data.
- snk_valid  in  1  stream beat valid.
- snk_ready  out  1  stream ready; a beat is accepted when valid & ready.
- m_address  out  ADDR_W  OCM word address.
- m_chipselect  out  1  OCM select.
- m_write  out  1  OCM write strobe.
- m_byteenable  out  4  always 4'hF.
- m_writedata  out  32  OCM write data.
- m_clken  out  1  always 1.
- csr_address  in  2  CSR word select.
- csr_read  in  1  CSR read strobe.
- csr_write  in  1  CSR write strobe.
- csr_writedata  in  32  CSR write data.
- csr_readdata  out  32  CSR read data, 1-cycle latency.
- irq  out  1  level interrupt, registered.

Behaviour:
- Reset (async, reset_n=0): all pointers, registers and outputs are 0; snk_ready=0; m_byteenable=4'hF and m_clken=1 are constant.
- Pointers wr_ptr and rd_ptr are ADDR_W+1 bits wide. count = wr_ptr - rd_ptr modulo 2**(ADDR_W+1). empty when count=0; full when count=2**ADDR_W.
- Ready rule:
  - DROP_WHEN_FULL=0: snk_ready = en & ~full (combinational from registered state).
  - DROP_WHEN_FULL=1: snk_ready = en.
- Accept (valid & ready & ~full) at cycle T:
  - At T+1: m_chipselect=1, m_write=1, m_address=wr_ptr[ADDR_W-1:0] (pre-increment value), m_writedata=snk_data.
  - wr_ptr increments at T+1 and wraps naturally at 2**(ADDR_W+1).
  - Back-to-back beats give one OCM write per cycle. m_write is 0 in all other cycles.
- Drop (DROP_WHEN_FULL=1, valid & en & full): no OCM write, wr_ptr unchanged, ovf set (sticky).
- CSR map, word addresses; reads return data the cycle after csr_read:
  - 0 CTRL: bit0 en (RW); bit1 clear (WO, self-clearing, reads 0); bit2 irq_en (RW); bits[ADDR_W+16:16] thresh (RW).
  - 1 WR_PTR: RO, zero-extended.
  - 2 RD_PTR: RW. A write is accepted only if the resulting count <= 2**ADDR_W; otherwise it is ignored and err is set (sticky).
  - 3 STATUS: bits[ADDR_W:0] count; bit16 empty; bit17 full; bit18 ovf (W1C); bit19 err (W1C).
- Clear (CTRL write with bit1=1 at cycle T): at T+1, wr_ptr=rd_ptr=0 and ovf=err=0. Clear has priority over a simultaneous accept: that beat's OCM write still issues but is discarded by the pointer reset. en, irq_en and thresh take the written values.
- Simultaneous accept and RD_PTR write in the same cycle: both apply. The legality check uses the post-accept wr_ptr.
- Disabling (en=0) mid-stream: a write already in flight completes; no further accepts.
- irq: registered; irq = irq_en & (thresh!=0) & (count >= thresh), evaluated on next-state count. It stays asserted until the CPU advances rd_ptr below thresh.
- Reads of unmapped bits return 0.

Test Plan:
- Reset, then en=1, 3 beats 0xA0,0xA1,0xA2 back-to-back -> OCM writes at addresses 0,1,2 on consecutive cycles; WR_PTR=3; STATUS count=3.
- DROP_WHEN_FULL=0, 2048 beats with no RD_PTR update -> full=1, snk_ready=0 after the last beat. RD_PTR write 1 -> ready returns the next cycle and the next beat goes to address 0 (wrap), WR_PTR=2049.
- DROP_WHEN_FULL=1, fill to 2048, push 5 more -> no OCM writes, ovf=1, count stays 2048. W1C of bit18 -> ovf=0.
- RD_PTR write 10 while WR_PTR=5 -> ignored, RD_PTR stays 0, err=1.
- thresh=4, irq_en=1, push 4 beats -> irq rises the cycle after the 4th accept. RD_PTR write 1 -> irq falls the following cycle.
- Clear asserted in the same cycle as an accepted beat -> WR_PTR=RD_PTR=0 next cycle, count=0; assert reset_n low mid-burst -> all outputs 0 immediately (asynchronous).
